// File: rtl/rc4_encrypt_writer.sv
// RC4 encryptor: key schedule + keystream over a private 256x8 S-memory, writes MSG_LEN ct bytes.
// Latency: start in cycle 0 -> INIT 1..256, KSA 257..2304, 12 cycles/byte PRGA, done at 2305+12*MSG_LEN.
// Backpressure: none; start is ignored while busy, plaintext must be held stable until done.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   start_i                   begin encryption (sampled in IDLE only)
//   secret_key_i[23:0]        key bytes: [23:16], [15:8], [7:0]
//   plain_data_i[MSG_LEN]     plaintext bytes, index 0 first
//   s_address_o/s_data_o/s_wren_o/s_q_i   S-memory port (read data 2 cycles after address)
//   ct_address_o/ct_data_o/ct_wren_o      ciphertext RAM write port
//   busy_o, done_o            busy while working, one-cycle done pulse
module rc4_encrypt_writer #(
   parameter int MSG_LEN = 32
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [23:0] secret_key_i,
   input  logic [7:0]  plain_data_i [MSG_LEN],
   output logic [7:0]  s_address_o,
   output logic [7:0]  s_data_o,
   output logic        s_wren_o,
   input  logic [7:0]  s_q_i,
   output logic [4:0]  ct_address_o,
   output logic [7:0]  ct_data_o,
   output logic        ct_wren_o,
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [4:0] {
      IDLE,
      INIT,
      K_RD_I, K_WT_I, K_LAT_I,
      K_RD_J, K_WT_J, K_LAT_J,
      K_WR_I, K_WR_J,
      P_INC,
      P_RD_I, P_WT_I, P_LAT_I,
      P_RD_J, P_WT_J, P_LAT_J,
      P_WR_I, P_WR_J,
      P_RD_F, P_WT_F, P_LAT_F,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  i_q, i_d;
   logic [7:0]  j_q, j_d;
   logic [4:0]  k_q, k_d;
   logic [1:0]  km_q, km_d;      // i mod 3, kept as a wrapping counter
   logic [23:0] key_q, key_d;
   logic [7:0]  si_q, si_d;
   logic [7:0]  sj_q, sj_d;

   logic [7:0]  key_byte;
   logic [7:0]  pt_byte;

   // Key byte selected by the running i mod 3 counter.
   always_comb begin
      key_byte = key_q[7:0];
      case (km_q)
         2'd0:    key_byte = key_q[23:16];
         2'd1:    key_byte = key_q[15:8];
         default: key_byte = key_q[7:0];
      endcase
   end

   // Plaintext byte for the current k; a compare-mux keeps the index in range for any MSG_LEN.
   always_comb begin
      pt_byte = 8'h00;
      for (int n = 0; n < MSG_LEN; n++) begin
         if (k_q == 5'(n)) pt_byte = plain_data_i[n];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         i_q     <= 8'h00;
         j_q     <= 8'h00;
         k_q     <= 5'h00;
         km_q    <= 2'd0;
         key_q   <= 24'h000000;
         si_q    <= 8'h00;
         sj_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         km_q    <= km_d;
         key_q   <= key_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      j_d          = j_q;
      k_d          = k_q;
      km_d         = km_q;
      key_d        = key_q;
      si_d         = si_q;
      sj_d         = sj_q;
      s_address_o  = 8'h00;
      s_data_o     = 8'h00;
      s_wren_o     = 1'b0;
      ct_address_o = 5'h00;
      ct_data_o    = 8'h00;
      ct_wren_o    = 1'b0;
      busy_o       = 1'b1;
      done_o       = 1'b0;

      case (state_q)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               key_d   = secret_key_i;
               i_d     = 8'h00;
               j_d     = 8'h00;
               k_d     = 5'h00;
               state_d = INIT;
            end
         end

         INIT: begin
            s_wren_o    = 1'b1;
            s_address_o = i_q;
            s_data_o    = i_q;
            i_d         = i_q + 8'd1;
            if (i_q == 8'hFF) begin
               j_d     = 8'h00;
               km_d    = 2'd0;
               state_d = K_RD_I;
            end
         end

         // Key schedule: read s[i], read s[j], swap.
         K_RD_I: begin
            s_address_o = i_q;
            state_d     = K_WT_I;
         end
         K_WT_I: begin
            s_address_o = i_q;
            state_d     = K_LAT_I;
         end
         K_LAT_I: begin
            si_d    = s_q_i;
            j_d     = j_q + s_q_i + key_byte;
            km_d    = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
            state_d = K_RD_J;
         end
         K_RD_J: begin
            s_address_o = j_q;
            state_d     = K_WT_J;
         end
         K_WT_J: begin
            s_address_o = j_q;
            state_d     = K_LAT_J;
         end
         K_LAT_J: begin
            sj_d    = s_q_i;
            state_d = K_WR_I;
         end
         K_WR_I: begin
            s_wren_o    = 1'b1;
            s_address_o = i_q;
            s_data_o    = sj_q;
            state_d     = K_WR_J;
         end
         K_WR_J: begin
            s_wren_o    = 1'b1;
            s_address_o = j_q;
            s_data_o    = si_q;
            i_d         = i_q + 8'd1;
            if (i_q == 8'hFF) begin
               // i has wrapped to 0; the keystream phase also starts with j = 0.
               j_d     = 8'h00;
               state_d = P_INC;
            end else begin
               state_d = K_RD_I;
            end
         end

         // Keystream generation, one ciphertext byte per pass.
         P_INC: begin
            i_d     = i_q + 8'd1;
            state_d = P_RD_I;
         end
         P_RD_I: begin
            s_address_o = i_q;
            state_d     = P_WT_I;
         end
         P_WT_I: begin
            s_address_o = i_q;
            state_d     = P_LAT_I;
         end
         P_LAT_I: begin
            si_d    = s_q_i;
            j_d     = j_q + s_q_i;
            state_d = P_RD_J;
         end
         P_RD_J: begin
            s_address_o = j_q;
            state_d     = P_WT_J;
         end
         P_WT_J: begin
            s_address_o = j_q;
            state_d     = P_LAT_J;
         end
         P_LAT_J: begin
            sj_d    = s_q_i;
            state_d = P_WR_I;
         end
         P_WR_I: begin
            s_wren_o    = 1'b1;
            s_address_o = i_q;
            s_data_o    = sj_q;
            state_d     = P_WR_J;
         end
         P_WR_J: begin
            s_wren_o    = 1'b1;
            s_address_o = j_q;
            s_data_o    = si_q;
            state_d     = P_RD_F;
         end
         P_RD_F: begin
            s_address_o = si_q + sj_q;
            state_d     = P_WT_F;
         end
         P_WT_F: begin
            s_address_o = si_q + sj_q;
            state_d     = P_LAT_F;
         end
         P_LAT_F: begin
            ct_wren_o    = 1'b1;
            ct_address_o = k_q;
            ct_data_o    = s_q_i ^ pt_byte;
            k_d          = k_q + 5'd1;
            state_d      = (k_q == 5'(MSG_LEN - 1)) ? DONE : P_INC;
         end

         DONE: begin
            busy_o  = 1'b0;
            done_o  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            busy_o  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rc4_encrypt_writer.sv
// Bench for rc4_encrypt_writer: a MSG_LEN=9 and a MSG_LEN=32 instance run side by side,
// each with its own 2-cycle-latency S-memory, checked against an array-based RC4 model.
module tb_rc4_encrypt_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start9, start32;
   logic [23:0] secret_key;
   logic [7:0]  plain9  [9];
   logic [7:0]  plain32 [32];

   logic [7:0]  s_address  [2];
   logic [7:0]  s_data     [2];
   logic        s_wren     [2];
   logic [7:0]  s_q        [2];
   logic [4:0]  ct_address [2];
   logic [7:0]  ct_data    [2];
   logic        ct_wren    [2];
   logic        busy       [2];
   logic        done       [2];

   rc4_encrypt_writer #(.MSG_LEN(9)) u_dut9 (
      .clk_i(clk), .reset_i(reset), .start_i(start9), .secret_key_i(secret_key),
      .plain_data_i(plain9),
      .s_address_o(s_address[0]), .s_data_o(s_data[0]), .s_wren_o(s_wren[0]), .s_q_i(s_q[0]),
      .ct_address_o(ct_address[0]), .ct_data_o(ct_data[0]), .ct_wren_o(ct_wren[0]),
      .busy_o(busy[0]), .done_o(done[0])
   );

   rc4_encrypt_writer #(.MSG_LEN(32)) u_dut32 (
      .clk_i(clk), .reset_i(reset), .start_i(start32), .secret_key_i(secret_key),
      .plain_data_i(plain32),
      .s_address_o(s_address[1]), .s_data_o(s_data[1]), .s_wren_o(s_wren[1]), .s_q_i(s_q[1]),
      .ct_address_o(ct_address[1]), .ct_data_o(ct_data[1]), .ct_wren_o(ct_wren[1]),
      .busy_o(busy[1]), .done_o(done[1])
   );

   // S-memories: registered address, then registered data -> 2-cycle read latency.
   logic [7:0] smem    [2][256];
   logic [7:0] saddr_q [2];
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (s_wren[d]) smem[d][s_address[d]] <= s_data[d];
         saddr_q[d] <= s_address[d];
         s_q[d]     <= smem[d][saddr_q[d]];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Reference keystream, computed straight from the RC4 definition.
   int ks [32];
   task automatic rc4_ref(input logic [23:0] key);
      int s [256];
      int kb [3];
      int i, j, t;
      kb[0] = int'(key[23:16]);
      kb[1] = int'(key[15:8]);
      kb[2] = int'(key[7:0]);
      for (int n = 0; n < 256; n++) s[n] = n;
      j = 0;
      for (int n = 0; n < 256; n++) begin
         j = (j + s[n] + kb[n % 3]) % 256;
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      i = 0; j = 0;
      for (int k = 0; k < 32; k++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         ks[k] = s[(s[i] + s[j]) % 256];
      end
   endtask

   // Per-run observation logs.
   int ct_mem [2][32];
   int ct_cyc [2][32];
   int ct_cnt [2];
   int done_cnt [2];
   int done_cyc [2];
   int busy_err [2];
   int init_err [2];
   int both_err [2];

   function automatic int plain_at(input int d, input int k);
      return (d == 1) ? int'(plain32[k]) : int'(plain9[k]);
   endfunction

   function automatic logic [7:0] rand_char();
      int v;
      v = $urandom_range(0, 26);
      return (v == 26) ? 8'h20 : 8'(8'h61 + v);
   endfunction

   task automatic rand_plain();
      for (int k = 0; k < 9; k++)  plain9[k]  = rand_char();
      for (int k = 0; k < 32; k++) plain32[k] = rand_char();
   endtask

   // One encryption on both instances. rst_at != 0 asserts reset in that cycle;
   // repulse re-pulses start at cycles 5 and 2000; start_at_done pulses start32 in its done cycle.
   task automatic run(input logic [23:0] key, input int rst_at, input bit repulse, input bit start_at_done);
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 32; k++) begin
            ct_mem[d][k] = -1;
            ct_cyc[d][k] = -1;
         end
         ct_cnt[d] = 0; done_cnt[d] = 0; done_cyc[d] = -1;
         busy_err[d] = 0; init_err[d] = 0; both_err[d] = 0;
      end
      @(negedge clk);
      secret_key = key;
      start9  = 1'b1;
      start32 = 1'b1;
      for (int cyc = 1; cyc <= 2700; cyc++) begin
         @(negedge clk);
         start9  = repulse && (cyc == 5 || cyc == 2000);
         start32 = (repulse && (cyc == 5 || cyc == 2000)) || (start_at_done && cyc == 2689);
         reset   = (rst_at != 0) && (cyc == rst_at);
         for (int d = 0; d < 2; d++) begin
            int  n;
            bit  live;
            n    = (d == 1) ? 32 : 9;
            live = (rst_at == 0) || (cyc <= rst_at);
            if (ct_wren[d]) begin
               ct_cnt[d]++;
               if (int'(ct_address[d]) < n) begin
                  ct_mem[d][ct_address[d]] = int'(ct_data[d]);
                  ct_cyc[d][ct_address[d]] = cyc;
               end
            end
            if (s_wren[d] && ct_wren[d]) both_err[d]++;
            if (done[d]) begin
               done_cnt[d]++;
               done_cyc[d] = cyc;
            end
            if (busy[d] !== ((cyc <= 2304 + 12 * n) && live)) busy_err[d]++;
            if (cyc <= 256 && live) begin
               if (!s_wren[d] || int'(s_address[d]) != cyc - 1 || int'(s_data[d]) != cyc - 1)
                  init_err[d]++;
            end
            if (cyc == 257 && (rst_at == 0 || rst_at > 257)) begin
               for (int a = 0; a < 256; a++)
                  if (int'(smem[d][a]) != a) init_err[d]++;
            end
            if (rst_at != 0 && cyc == rst_at + 1) begin
               chk("rst_busy", int'(busy[d]), 0);
               chk("rst_s_wren", int'(s_wren[d]), 0);
               chk("rst_ct_wren", int'(ct_wren[d]), 0);
               chk("rst_s_addr", int'(s_address[d]), 0);
               chk("rst_done", int'(done[d]), 0);
            end
         end
         if (rst_at != 0 && cyc == rst_at + 10) break;
      end
      start9  = 1'b0;
      start32 = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_result(input int d);
      int n;
      n = (d == 1) ? 32 : 9;
      chk("done_cnt", done_cnt[d], 1);
      chk("done_cyc", done_cyc[d], 2305 + 12 * n);
      chk("ct_cnt", ct_cnt[d], n);
      chk("busy_err", busy_err[d], 0);
      chk("init_err", init_err[d], 0);
      chk("both_wren", both_err[d], 0);
      for (int k = 0; k < n; k++) begin
         chk("ct_byte", ct_mem[d][k], ks[k] ^ plain_at(d, k));
         chk("ct_cycle", ct_cyc[d][k], 2304 + 12 * (k + 1));
      end
   endtask

   task automatic standard_vector();
      int stdv [9];
      stdv = '{'hBB, 'hF3, 'h16, 'hE8, 'hD9, 'h40, 'hAF, 'h0A, 'hD3};
      plain9 = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      for (int k = 0; k < 32; k++) plain32[k] = rand_char();
      rc4_ref(24'h4B6579);
      run(24'h4B6579, 0, 1'b0, 1'b0);
      check_result(0);
      check_result(1);
      for (int k = 0; k < 9; k++) chk("std_ct", ct_mem[0][k], stdv[k]);
   endtask

   initial begin
      logic [23:0] key;
      int bad;
      reset = 1'b1; start9 = 1'b0; start32 = 1'b0; secret_key = 24'h0;
      for (int k = 0; k < 9; k++)  plain9[k]  = 8'h00;
      for (int k = 0; k < 32; k++) plain32[k] = 8'h00;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_busy", int'(busy[d]), 0);
         chk("reset_done", int'(done[d]), 0);
         chk("reset_s_wren", int'(s_wren[d]), 0);
         chk("reset_ct_wren", int'(ct_wren[d]), 0);
         chk("reset_s_addr", int'(s_address[d]), 0);
         chk("reset_s_data", int'(s_data[d]), 0);
         chk("reset_ct_addr", int'(ct_address[d]), 0);
         chk("reset_ct_data", int'(ct_data[d]), 0);
      end
      reset = 1'b0;
      @(negedge clk);

      standard_vector();

      // Round trip with start re-pulsed while busy and in the done cycle.
      rand_plain();
      rc4_ref(24'h000249);
      run(24'h000249, 0, 1'b1, 1'b1);
      check_result(0);
      check_result(1);
      bad = 0;
      for (int k = 0; k < 32; k++) begin
         int dec;
         dec = ct_mem[1][k] ^ ks[k];
         chk("roundtrip", dec, int'(plain32[k]));
         if (!((dec >= 'h61 && dec <= 'h7A) || dec == 'h20)) bad++;
      end
      chk("valid_text", bad, 0);

      // Zero plaintext: ciphertext is the bare keystream.
      for (int k = 0; k < 9; k++)  plain9[k]  = 8'h00;
      for (int k = 0; k < 32; k++) plain32[k] = 8'h00;
      key = 24'($urandom);
      rc4_ref(key);
      run(key, 0, 1'b0, 1'b0);
      check_result(0);
      check_result(1);

      // Reset mid-KSA, then a clean restart.
      rand_plain();
      run(24'($urandom), 1000, 1'b0, 1'b0);
      chk("rst_no_done9", done_cnt[0], 0);
      chk("rst_no_done32", done_cnt[1], 0);
      standard_vector();

      // Reset and start together: reset wins.
      @(negedge clk);
      reset = 1'b1; start9 = 1'b1; start32 = 1'b1;
      @(negedge clk);
      reset = 1'b0; start9 = 1'b0; start32 = 1'b0;
      chk("rst_start_busy9", int'(busy[0]), 0);
      chk("rst_start_busy32", int'(busy[1]), 0);
      @(negedge clk);
      chk("rst_start_idle9", int'(busy[0]), 0);
      chk("rst_start_idle32", int'(s_wren[1]), 0);

      // Random keys and text.
      for (int r = 0; r < 2; r++) begin
         rand_plain();
         key = 24'($urandom);
         rc4_ref(key);
         run(key, 0, 1'b0, 1'b0);
         check_result(0);
         check_result(1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rc4_encrypt_writer.md
# rc4_encrypt_writer

Produces RC4 ciphertext from a 24-bit secret key and a MSG_LEN-byte lowercase plaintext. It writes the result byte-by-byte into a 32x8 ciphertext RAM. This is the encryption end of the key-search path: the RAM image it writes is what the breaker reads back as encrypted data and attacks with the decryption core. The block owns a 256x8 single-port S-memory for its own key schedule and runs init, KSA and PRGA sequentially under one FSM.

## Interface
- MSG_LEN, 32, number of message bytes encrypted and written (1..32)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns FSM to IDLE
- start  in  1  begin encryption when sampled high in IDLE
- secret_key  in  24  key; byte0 = [23:16], byte1 = [15:8], byte2 = [7:0]
- plain_data  in  8 x MSG_LEN (unpacked array)  plaintext, index 0 first; held stable by producer until done
- s_address  out  8  S-memory address
- s_data  out  8  S-memory write data
- s_wren  out  1  S-memory write enable
- s_q  in  8  S-memory read data; valid 2 cycles after the cycle the address is driven
- ct_address  out  5  ciphertext RAM address (byte index k)
- ct_data  out  8  ciphertext byte
- ct_wren  out  1  ciphertext RAM write enable, one cycle per byte
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last ciphertext write

## Operation
- IDLE: on start=1, latch secret_key into a key register, clear i, j, k, and go to INIT. start while busy is ignored.
- INIT: one state, 256 cycles. Write s[i]=i for i=0..255 (s_wren=1, s_address=i, s_data=i), then clear i and j.
- KSA: 8 states per i, run for i=0..255.
  - K_RD_I (address i), K_WT_I, K_LAT_I (si=s_q; j=j+si+key[i mod 3], mod 256).
  - K_RD_J (address j), K_WT_J, K_LAT_J (sj=s_q).
  - K_WR_I (write s[i]=sj), K_WR_J (write s[j]=si; i++).
  - The i mod 3 index is a 2-bit counter wrapping 2->0, not a divider.
- PRGA: 12 states per byte, run for k=0..MSG_LEN-1. i and j are cleared on entry.
  - P_INC (i=i+1 mod 256).
  - P_RD_I, P_WT_I, P_LAT_I (si=s_q; j=j+si).
  - P_RD_J, P_WT_J, P_LAT_J (sj=s_q).
  - P_WR_I (s[i]=sj), P_WR_J (s[j]=si).
  - P_RD_F (address si+sj mod 256), P_WT_F.
  - P_LAT_F: ct_wren=1, ct_address=k, ct_data=s_q ^ plain_data[k]; k++. Exit to DONE when k=MSG_LEN-1.
- DONE: done=1 for one cycle, then IDLE.
- All 8-bit index arithmetic wraps modulo 256 and carries are discarded.
- When i==j, the swap writes the same value twice. This is legal and needs no special case.
- s_wren and ct_wren are never high in the same cycle. s_wren is high only in INIT, K_WR_*, P_WR_*.
- Address and data outputs are don't-care when their enable is low. They are driven 0 in IDLE.

## Timing
- Reset values: s_address=0, s_data=0, s_wren=0, ct_address=0, ct_data=0, ct_wren=0, busy=0, done=0. FSM is in IDLE.
- start sampled in cycle 0:
  - INIT occupies cycles 1..256.
  - KSA occupies cycles 257..2304.
  - PRGA occupies cycles 2305..2304+12*MSG_LEN.
  - done is high in cycle 2305+12*MSG_LEN (2689 for MSG_LEN=32).
- The ciphertext write for byte k occurs in cycle 2304+12*(k+1).
- busy is high for cycles 1..2304+12*MSG_LEN and low in the done cycle.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. Partially written ct RAM contents are undefined. No done pulse is issued.
- start asserted in the done cycle is ignored. The next start is accepted in IDLE one cycle later.
- Reset and start high in the same cycle: reset wins and the FSM stays IDLE.

## Test plan
- Standard vector: MSG_LEN=9, secret_key=24'h4B6579 ("Key"), plain_data="Plaintext" -> ct bytes BB F3 16 E8 D9 40 AF 0A D3 at addresses 0..8; done at cycle 2413.
- INIT check: start with any key; at cycle 256, S-memory model holds s[i]=i for all i; 256 consecutive writes, no reads.
- Round trip: MSG_LEN=32, key 24'h000249, 32 random lowercase/space bytes. Encrypt, then run the decryption core with the same key on the ct RAM -> decrypted bytes equal plaintext and the validator reports valid.
- Zero plaintext: plain_data all 8'h00 -> ct bytes equal the reference-model keystream; exactly 32 ct_wren pulses, at cycles 2316+12k.
- Reset at cycle 1000 (mid-KSA): next cycle busy=0 and all enables 0. A restart then produces the correct full result and the standard vector passes.
- start re-pulsed at cycles 5 and 2000 while busy -> ignored: single done pulse, identical ciphertext.
